// File: rtl/rule110_seq_pkg.sv
// Shared types and defaults for the rule110 array sequencer.
// Command opcodes, FSM states and the default bus widths live here.
package rule110_seq_pkg;

  localparam int CELLS_PER_BLOCK = 8;
  localparam int DEF_ADDR_W      = 6;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_GEN_W       = 32;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_RUN   = 2'd2,
    OP_DUMP  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_RUN    = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

endpackage

// File: rtl/rule110_run_counter.sv
// Loadable down-counter for RUN: holds the generations still to advance.
// zero_o means nothing left; last_o means the next advance is the final one.
module rule110_run_counter #(
  parameter int CNT_W = rule110_seq_pkg::DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o,
  output logic             last_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);
  assign last_o = (count_q == CNT_W'(1));

endmodule

// File: rtl/rule110_sequencer.sv
// Turns host WRITE/READ/RUN/DUMP commands into registered pin-level control
// of the rule110 cell array; the array is halted whenever it is not in RUN.
module rule110_sequencer
  import rule110_seq_pkg::*;
#(
  parameter int NUM_CELLS = 64,
  parameter int BLOCKS    = NUM_CELLS / CELLS_PER_BLOCK,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int GEN_W     = DEF_GEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_data,
  input  logic [CNT_W-1:0]  cmd_count,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [7:0]        rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_last,
  output logic              rsp_err,
  output logic [7:0]        ca_data_in,
  output logic              ca_we_n,
  output logic              ca_halt_n,
  output logic [ADDR_W-1:0] ca_addr,
  input  logic [7:0]        ca_data_out,
  output logic [GEN_W-1:0]  generation,
  output logic              busy
);

  localparam logic [ADDR_W:0]   BLOCKS_CMP = (ADDR_W + 1)'(BLOCKS);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BLOCKS - 1);

  state_e state_q, state_d;

  logic              ca_we_n_q, ca_we_n_d;
  logic              ca_halt_n_q, ca_halt_n_d;
  logic [ADDR_W-1:0] ca_addr_q, ca_addr_d;
  logic [7:0]        ca_data_in_q, ca_data_in_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [7:0]        rsp_data_q, rsp_data_d;
  logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
  logic              rsp_last_q, rsp_last_d;
  logic              rsp_err_q, rsp_err_d;
  logic [GEN_W-1:0]  gen_q, gen_d;
  logic              dump_q, dump_d;
  logic              rd_err_q, rd_err_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;

  logic cmd_fire;
  logic addr_ok;
  logic resp_fire;
  logic dump_more;
  logic cnt_load, cnt_dec, cnt_zero, cnt_last;
  op_e  op;

  // Both ports use valid/ready: a transfer happens at a rising edge where
  // valid and ready are both high; the sender holds its payload until then.
  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = ~cmd_ready;
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign op        = op_e'(cmd_op);
  assign addr_ok   = ({1'b0, cmd_addr} < BLOCKS_CMP);
  assign resp_fire = (state_q == ST_RESP) & rsp_ready;
  assign dump_more = dump_q & (ca_addr_q != LAST_ADDR);

  rule110_run_counter #(
    .CNT_W(CNT_W)
  ) u_run_counter (
    .clk       (clk),
    .reset     (reset),
    .load_i    (cnt_load),
    .load_val_i(cmd_count),
    .dec_i     (cnt_dec),
    .zero_o    (cnt_zero),
    .last_o    (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          case (op)
            OP_WRITE: state_d = ST_WRITE;
            OP_RUN:   state_d = ST_RUN;
            default:  state_d = ST_SAMPLE;
          endcase
        end
      end
      ST_WRITE:  state_d = ST_IDLE;
      ST_RUN:    if (cnt_zero || cnt_last) state_d = ST_IDLE;
      ST_SAMPLE: state_d = ST_RESP;
      ST_RESP:   if (rsp_ready) state_d = dump_more ? ST_SAMPLE : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ca_we_n_d    = ca_we_n_q;
    ca_halt_n_d  = ca_halt_n_q;
    ca_addr_d    = ca_addr_q;
    ca_data_in_d = ca_data_in_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_addr_d   = rsp_addr_q;
    rsp_last_d   = rsp_last_q;
    rsp_err_d    = rsp_err_q;
    gen_d        = gen_q;
    dump_d       = dump_q;
    rd_err_d     = rd_err_q;
    req_addr_d   = req_addr_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          dump_d   = 1'b0;
          rd_err_d = 1'b0;
          case (op)
            OP_WRITE: begin
              // Out-of-range writes still pass through WRITE but never strobe.
              if (addr_ok) begin
                ca_we_n_d    = 1'b0;
                ca_addr_d    = cmd_addr;
                ca_data_in_d = cmd_data;
              end
            end
            OP_RUN: begin
              cnt_load    = 1'b1;
              ca_halt_n_d = (cmd_count != '0);
            end
            OP_READ: begin
              req_addr_d = cmd_addr;
              if (addr_ok) ca_addr_d = cmd_addr;
              else         rd_err_d  = 1'b1;
            end
            default: begin
              dump_d    = 1'b1;
              ca_addr_d = '0;
            end
          endcase
        end
      end
      ST_WRITE: ca_we_n_d = 1'b1;
      ST_RUN: begin
        if (!cnt_zero) begin
          cnt_dec = 1'b1;
          gen_d   = gen_q + GEN_W'(1);
          if (cnt_last) ca_halt_n_d = 1'b0;
        end
      end
      ST_SAMPLE: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = rd_err_q ? 8'h00 : ca_data_out;
        rsp_addr_d  = rd_err_q ? req_addr_q : ca_addr_q;
        rsp_err_d   = rd_err_q;
        rsp_last_d  = ~dump_more;
      end
      ST_RESP: begin
        if (resp_fire) begin
          rsp_valid_d = 1'b0;
          rsp_last_d  = 1'b0;
          rsp_err_d   = 1'b0;
          if (dump_more) ca_addr_d = ca_addr_q + ADDR_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ca_we_n_q    <= 1'b1;
      ca_halt_n_q  <= 1'b0;
      ca_addr_q    <= '0;
      ca_data_in_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_addr_q   <= '0;
      rsp_last_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      gen_q        <= '0;
      dump_q       <= 1'b0;
      rd_err_q     <= 1'b0;
      req_addr_q   <= '0;
    end else begin
      ca_we_n_q    <= ca_we_n_d;
      ca_halt_n_q  <= ca_halt_n_d;
      ca_addr_q    <= ca_addr_d;
      ca_data_in_q <= ca_data_in_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_addr_q   <= rsp_addr_d;
      rsp_last_q   <= rsp_last_d;
      rsp_err_q    <= rsp_err_d;
      gen_q        <= gen_d;
      dump_q       <= dump_d;
      rd_err_q     <= rd_err_d;
      req_addr_q   <= req_addr_d;
    end
  end

  assign ca_we_n    = ca_we_n_q;
  assign ca_halt_n  = ca_halt_n_q;
  assign ca_addr    = ca_addr_q;
  assign ca_data_in = ca_data_in_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_addr   = rsp_addr_q;
  assign rsp_last   = rsp_last_q;
  assign rsp_err    = rsp_err_q;
  assign generation = gen_q;

endmodule

// File: tb/tb_rule110_sequencer.sv
// Directed bench for rule110_sequencer with a behavioural 64-cell rule110
// array (wrap-around, seeded with cell 0 set) attached to the array pins.
module tb_rule110_sequencer;
  import rule110_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [5:0]  cmd_addr = 6'd0;
  logic [7:0]  cmd_data = 8'd0;
  logic [15:0] cmd_count = 16'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_data;
  logic [5:0]  rsp_addr;
  logic        rsp_last;
  logic        rsp_err;
  logic [7:0]  ca_data_in;
  logic        ca_we_n;
  logic        ca_halt_n;
  logic [5:0]  ca_addr;
  logic [7:0]  ca_data_out;
  logic [31:0] generation;
  logic        busy;

  int checks = 0;
  int errors = 0;

  rule110_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .cmd_count  (cmd_count),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_addr   (rsp_addr),
    .rsp_last   (rsp_last),
    .rsp_err    (rsp_err),
    .ca_data_in (ca_data_in),
    .ca_we_n    (ca_we_n),
    .ca_halt_n  (ca_halt_n),
    .ca_addr    (ca_addr),
    .ca_data_out(ca_data_out),
    .generation (generation),
    .busy       (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural cell array: left neighbour of cell i is i+1, right is i-1
  logic [63:0] cells;
  logic [63:0] nxt;

  function automatic logic r110(input logic l, input logic c, input logic r);
    case ({l, c, r})
      3'b110, 3'b101, 3'b011, 3'b010, 3'b001: r110 = 1'b1;
      default:                                r110 = 1'b0;
    endcase
  endfunction

  always_comb begin
    nxt = '0;
    for (int i = 0; i < 64; i++) begin
      nxt[i] = r110(cells[(i + 1) % 64], cells[i], cells[(i + 63) % 64]);
    end
  end

  assign ca_data_out = (ca_addr < 6'd8) ? nxt[{ca_addr[2:0], 3'b000} +: 8] : 8'h00;

  always @(posedge clk) begin
    if (reset)          cells <= 64'h1;
    else if (!ca_we_n)  cells[{ca_addr[2:0], 3'b000} +: 8] <= ca_data_in;
    else if (ca_halt_n) cells <= nxt;
  end

  // pin activity monitor
  int halt_cyc = 0;
  int we_cyc = 0;
  bit both_seen = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (ca_halt_n)              halt_cyc  <= halt_cyc + 1;
      if (!ca_we_n)               we_cyc    <= we_cyc + 1;
      if (ca_halt_n && !ca_we_n)  both_seen <= 1'b1;
    end
  end

  // scoreboard helpers
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!cmd_ready && n < 300) begin
      step();
      n++;
    end
    if (!cmd_ready) chk(tag, 64'(cmd_ready), 64'h1);
  endtask

  // driver tasks
  task automatic do_reset();
    reset     = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic send_cmd(input op_e op, input logic [5:0] addr,
                          input logic [7:0] data, input logic [15:0] count);
    wait_idle("cmd_ready_timeout");
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    cmd_count = count;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic read_blk(input logic [5:0] addr, output logic [7:0] data,
                          output logic last, output logic err);
    int n = 0;
    send_cmd(OP_READ, addr, 8'h00, 16'd0);
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    if (!rsp_valid) chk("read_timeout", 64'(rsp_valid), 64'h1);
    data = rsp_data;
    last = rsp_last;
    err  = rsp_err;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  logic [7:0] d;
  logic       l, e;
  int         h0, w0;
  logic [7:0] dump_exp [8];

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset values, then READ 0 sees generation 1 of the seed
    reset = 1'b1;
    step();
    step();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'h1);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_we_n", 64'(ca_we_n), 64'h1);
    chk("rst_halt_n", 64'(ca_halt_n), 64'h0);
    chk("rst_ca_addr", 64'(ca_addr), 64'h0);
    chk("rst_ca_data_in", 64'(ca_data_in), 64'h0);
    chk("rst_rsp", 64'({rsp_valid, rsp_data, rsp_addr, rsp_last, rsp_err}), 64'h0);
    chk("rst_generation", 64'(generation), 64'h0);
    reset = 1'b0;
    read_blk(6'd0, d, l, e);
    chk("t1_data", 64'(d), 64'h03);
    chk("t1_last", 64'(l), 64'h1);
    chk("t1_err", 64'(e), 64'h0);
    chk("t1_gen", 64'(generation), 64'h0);
    chk("t1_rsp_valid_drop", 64'(rsp_valid), 64'h0);

    // 2: RUN 1
    do_reset();
    h0 = halt_cyc;
    send_cmd(OP_RUN, 6'd0, 8'h00, 16'd1);
    chk("t2_halt_n_high", 64'(ca_halt_n), 64'h1);
    wait_idle("t2_idle_timeout");
    chk("t2_halt_cycles", 64'(halt_cyc - h0), 64'h1);
    chk("t2_gen", 64'(generation), 64'h1);
    read_blk(6'd0, d, l, e);
    chk("t2_data", 64'(d), 64'h07);

    // 3: WRITE in range and out of range
    do_reset();
    w0 = we_cyc;
    send_cmd(OP_WRITE, 6'd1, 8'hFF, 16'd0);
    chk("t3_we_low", 64'(ca_we_n), 64'h0);
    chk("t3_we_addr", 64'(ca_addr), 64'h1);
    chk("t3_busy", 64'(busy), 64'h1);
    step();
    chk("t3_ready_after", 64'(cmd_ready), 64'h1);
    chk("t3_we_cycles", 64'(we_cyc - w0), 64'h1);
    read_blk(6'd1, d, l, e);
    chk("t3_read1", 64'(d), 64'h81);
    read_blk(6'd0, d, l, e);
    chk("t3_read0", 64'(d), 64'h03);
    w0 = we_cyc;
    send_cmd(OP_WRITE, 6'd8, 8'h55, 16'd0);
    chk("t3_oob_busy", 64'(busy), 64'h1);
    chk("t3_oob_we_n", 64'(ca_we_n), 64'h1);
    wait_idle("t3_idle_timeout");
    chk("t3_oob_we_cycles", 64'(we_cyc - w0), 64'h0);
    read_blk(6'd1, d, l, e);
    chk("t3_read1_again", 64'(d), 64'h81);

    // 4: DUMP with rsp_ready toggling; block 4 written with 0x10 first
    do_reset();
    send_cmd(OP_WRITE, 6'd4, 8'h10, 16'd0);
    wait_idle("t4_write_timeout");
    dump_exp[0] = 8'h03; dump_exp[1] = 8'h00; dump_exp[2] = 8'h00; dump_exp[3] = 8'h00;
    dump_exp[4] = 8'h30; dump_exp[5] = 8'h00; dump_exp[6] = 8'h00; dump_exp[7] = 8'h00;
    send_cmd(OP_DUMP, 6'd0, 8'h00, 16'd0);
    begin
      int k = 0;
      int cyc = 0;
      int stalls = 0;
      while (k < 8 && cyc < 100) begin
        rsp_ready = (cyc % 2 == 0);
        if (rsp_valid) begin
          chk($sformatf("t4_addr_%0d", k), 64'(rsp_addr), 64'(k));
          chk($sformatf("t4_data_%0d", k), 64'(rsp_data), 64'(dump_exp[k]));
          chk($sformatf("t4_last_%0d", k), 64'(rsp_last), (k == 7) ? 64'h1 : 64'h0);
          if (rsp_ready) k++;
          else           stalls++;
        end
        step();
        cyc++;
      end
      rsp_ready = 1'b0;
      chk("t4_responses", 64'(k), 64'h8);
      chk("t4_stalled", 64'(stalls > 0), 64'h1);
    end
    wait_idle("t4_idle_timeout");
    chk("t4_valid_drop", 64'(rsp_valid), 64'h0);

    // 5: RUN 0 and out-of-range READ
    do_reset();
    h0 = halt_cyc;
    send_cmd(OP_RUN, 6'd0, 8'h00, 16'd0);
    chk("t5_busy", 64'(busy), 64'h1);
    chk("t5_halt_n", 64'(ca_halt_n), 64'h0);
    step();
    chk("t5_ready", 64'(cmd_ready), 64'h1);
    chk("t5_gen", 64'(generation), 64'h0);
    chk("t5_halt_cycles", 64'(halt_cyc - h0), 64'h0);
    read_blk(6'd2, d, l, e);
    chk("t5_read2", 64'({d, e}), 64'h000);
    read_blk(6'd9, d, l, e);
    chk("t5_oob_data", 64'(d), 64'h00);
    chk("t5_oob_err", 64'(e), 64'h1);
    chk("t5_oob_last", 64'(l), 64'h1);
    chk("t5_oob_ca_addr", 64'(ca_addr), 64'h2);

    // 6: RUN 100 aborted by reset after 39 advances
    do_reset();
    send_cmd(OP_RUN, 6'd0, 8'h00, 16'd100);
    chk("t6_halt_n", 64'(ca_halt_n), 64'h1);
    repeat (39) step();
    chk("t6_gen_mid", 64'(generation), 64'd39);
    chk("t6_busy_mid", 64'(busy), 64'h1);
    reset = 1'b1;
    step();
    chk("t6_halt_n_abort", 64'(ca_halt_n), 64'h0);
    chk("t6_we_n_abort", 64'(ca_we_n), 64'h1);
    chk("t6_gen_abort", 64'(generation), 64'h0);
    chk("t6_ready_abort", 64'(cmd_ready), 64'h1);
    chk("t6_valid_abort", 64'(rsp_valid), 64'h0);
    reset = 1'b0;
    h0 = halt_cyc;
    send_cmd(OP_RUN, 6'd0, 8'h00, 16'd2);
    wait_idle("t6_idle_timeout");
    chk("t6_gen_after", 64'(generation), 64'h2);
    chk("t6_halt_cycles_after", 64'(halt_cyc - h0), 64'h2);

    chk("never_we_and_halt", 64'(both_seen), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
